// File: rtl/rmii_pkg.sv
// rmii_pkg
//   Shared constants for the RMII byte receiver: FSM state encodings, the
//   preamble/SFD dibit values, 10 Mbps timing constants and frame length
//   width, plus a saturating increment helper for the length counter.
package rmii_pkg;

  // FSM state encodings
  typedef logic [1:0] rmii_state_t;
  localparam rmii_state_t IDLE     = 2'd0;
  localparam rmii_state_t PREAMBLE = 2'd1;
  localparam rmii_state_t DATA     = 2'd2;

  // Dibit values seen on RXD[1:0] (LSB-first 0x55 preamble, 0xD5 SFD tail)
  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;

  // 10 Mbps: one dibit lasts SLOW_DIV RMII cycles, first sample SLOW_MID in
  localparam logic [3:0] SLOW_DIV = 4'd10;
  localparam logic [3:0] SLOW_MID = 4'd4;

  localparam int FRAME_LEN_W = 11;
  localparam logic [FRAME_LEN_W-1:0] FRAME_LEN_MAX = {FRAME_LEN_W{1'b1}};

  // Increment that sticks at FRAME_LEN_MAX instead of wrapping
  function automatic logic [FRAME_LEN_W-1:0] sat_inc(input logic [FRAME_LEN_W-1:0] v);
    if (v == FRAME_LEN_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(FRAME_LEN_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/rmii_rx_sampler.sv
// rmii_rx_sampler
//   Produces the per-dibit sample strobe for the RMII receiver.
//   Ports:
//     clk, rst      100 MHz clock, synchronous active-low reset
//     rmii_clk_i    50 MHz RMII clock, sampled as a level
//     fast_i        effective link speed (1 = 100 Mbps)
//     idle_i        receiver FSM is in IDLE
//     crs_dv_i      RMII CRS_DV
//     rearm_i       drop 10 Mbps phase lock (receiver returning to IDLE)
//     sample_o      sample strobe for this clk cycle
module rmii_rx_sampler
  import rmii_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rmii_clk_i,
  input  logic fast_i,
  input  logic idle_i,
  input  logic crs_dv_i,
  input  logic rearm_i,
  output logic sample_o
);

  logic       armed_q, armed_d;
  logic [3:0] phase_q, phase_d;

  // Strobe is combinational so the FSM samples RXD in the same rmii_clk-high
  // cycle the strobe refers to, before the PHY moves to the next dibit.
  always_comb begin
    if (fast_i) begin
      sample_o = rmii_clk_i;
    end else begin
      sample_o = rmii_clk_i && armed_q && (phase_q == 4'd0);
    end
  end

  // Phase counter next state: lock onto the first CRS_DV seen in IDLE, then
  // count RMII cycles so samples land mid-symbol, one per SLOW_DIV cycles.
  always_comb begin
    armed_d = armed_q;
    phase_d = phase_q;
    if (rearm_i) begin
      armed_d = 1'b0;
      phase_d = 4'd0;
    end else if (rmii_clk_i && !fast_i) begin
      if (!armed_q) begin
        if (idle_i && crs_dv_i) begin
          armed_d = 1'b1;
          phase_d = SLOW_MID;
        end else begin
          armed_d = 1'b0;
        end
      end else if (phase_q == 4'd0) begin
        phase_d = SLOW_DIV - 4'd1;
      end else begin
        phase_d = phase_q - 4'd1;
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // Phase counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      armed_q <= 1'b0;
      phase_q <= 4'd0;
    end else begin
      armed_q <= armed_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/rmii_recv_byte.sv
// rmii_recv_byte
//   Receives RMII frames, strips preamble/SFD and delivers bytes LSB-first.
//   Ports:
//     clk, rst           100 MHz clock, synchronous active-low reset
//     rmii_clk           50 MHz RMII clock (level)
//     fast_eth           1 = 100 Mbps, 0 = 10 Mbps (latched per frame)
//     rm_crs_dv          RMII CRS_DV
//     rm_rx_data         RMII RXD[1:0]
//     data / valid       received byte and its one-cycle strobe
//     sof / eof          frame start (SFD accepted) / frame end strobes
//     err                with eof: frame ended on a non-byte boundary
//     frame_len          byte count, presented with eof, saturating
//     busy               high from SFD acceptance through eof
module rmii_recv_byte
  import rmii_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rmii_clk,
  input  logic                   fast_eth,
  input  logic                   rm_crs_dv,
  input  logic [1:0]             rm_rx_data,
  output logic [7:0]             data,
  output logic                   valid,
  output logic                   sof,
  output logic                   eof,
  output logic                   err,
  output logic [FRAME_LEN_W-1:0] frame_len,
  output logic                   busy
);

  rmii_state_t            state_q, state_d;
  logic                   fast_q, fast_d;
  logic [7:0]             sr_q, sr_d;
  logic [1:0]             dcnt_q, dcnt_d;
  logic [FRAME_LEN_W-1:0] len_q, len_d;
  logic                   low_pend_q, low_pend_d;
  logic                   crs_prev_q, crs_prev_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   sof_q, sof_d;
  logic                   eof_q, eof_d;
  logic                   err_q, err_d;
  logic [FRAME_LEN_W-1:0] frame_len_q, frame_len_d;
  logic                   busy_q, busy_d;

  logic       sample_s;
  logic       fast_eff_s;
  logic       rearm_s;
  logic [7:0] shift_s;
  logic [1:0] eff_cnt_s;

  // Speed input is live only while IDLE; a frame keeps the speed it started with
  always_comb begin
    if (state_q == IDLE) begin
      fast_eff_s = fast_eth;
    end else begin
      fast_eff_s = fast_q;
    end
  end

  rmii_rx_sampler u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rmii_clk_i (rmii_clk),
    .fast_i     (fast_eff_s),
    .idle_i     (state_q == IDLE),
    .crs_dv_i   (rm_crs_dv),
    .rearm_i    (rearm_s),
    .sample_o   (sample_s)
  );

  assign shift_s   = {rm_rx_data, sr_q[7:2]};
  // A dibit accepted under a low CRS_DV may be a FIFO-drain artefact, so it
  // does not count towards the byte-alignment check.
  assign eff_cnt_s = dcnt_q - {1'b0, low_pend_q};

  // Receive FSM and datapath next state, advanced at sample points only
  always_comb begin
    state_d     = state_q;
    fast_d      = fast_q;
    sr_d        = sr_q;
    dcnt_d      = dcnt_q;
    len_d       = len_q;
    low_pend_d  = low_pend_q;
    crs_prev_d  = crs_prev_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    err_d       = err_q;
    frame_len_d = frame_len_q;
    rearm_s     = 1'b0;
    if (sample_s) begin
      crs_prev_d = rm_crs_dv;
      case (state_q)
        IDLE: begin
          if (rm_crs_dv && (rm_rx_data == PRE_DIBIT)) begin
            state_d = PREAMBLE;
            fast_d  = fast_eth;
          end else if (!rm_crs_dv) begin
            rearm_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        PREAMBLE: begin
          if (!rm_crs_dv || (rm_rx_data == 2'b10)) begin
            state_d = IDLE;
            rearm_s = 1'b1;
          end else if (rm_rx_data == SFD_DIBIT) begin
            state_d    = DATA;
            dcnt_d     = 2'd0;
            len_d      = {FRAME_LEN_W{1'b0}};
            low_pend_d = 1'b0;
            sof_d      = 1'b0 | 1'b1;
          end else begin
            state_d = PREAMBLE;
          end
        end
        DATA: begin
          // CRS_DV may toggle at the frame tail while the PHY drains its
          // FIFO; a low on an even dibit right after a high one is kept.
          if (rm_crs_dv || (crs_prev_q && !dcnt_q[0] && !low_pend_q)) begin
            low_pend_d = !rm_crs_dv;
            sr_d       = shift_s;
            dcnt_d     = dcnt_q + 2'd1;
            if (dcnt_q == 2'd3) begin
              data_d  = shift_s;
              valid_d = 1'b1;
              len_d   = sat_inc(len_q);
            end else begin
              valid_d = 1'b0;
            end
          end else begin
            eof_d       = 1'b1;
            err_d       = (eff_cnt_s != 2'd0);
            frame_len_d = len_q;
            state_d     = IDLE;
            rearm_s     = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          rearm_s = 1'b1;
        end
      endcase
    end else begin
      crs_prev_d = crs_prev_q;
    end
    busy_d = (state_d == DATA) || eof_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      fast_q      <= 1'b0;
      sr_q        <= 8'd0;
      dcnt_q      <= 2'd0;
      len_q       <= {FRAME_LEN_W{1'b0}};
      low_pend_q  <= 1'b0;
      crs_prev_q  <= 1'b0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      err_q       <= 1'b0;
      frame_len_q <= {FRAME_LEN_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fast_q      <= fast_d;
      sr_q        <= sr_d;
      dcnt_q      <= dcnt_d;
      len_q       <= len_d;
      low_pend_q  <= low_pend_d;
      crs_prev_q  <= crs_prev_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      err_q       <= err_d;
      frame_len_q <= frame_len_d;
      busy_q      <= busy_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign err       = err_q;
  assign frame_len = frame_len_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rmii_recv_byte.sv
`timescale 1ns/1ps
// tb_rmii_recv_byte
//   Table-driven frames at both speeds plus hand-written sequences for
//   preamble abort, mid-frame reset and length saturation.
module tb_rmii_recv_byte;

  localparam int T_NORMAL = 0;
  localparam int T_TOGGLE = 1;
  localparam int T_EXTRA3 = 2;

  typedef struct {
    logic            fast;
    int              n;
    logic [3:0][7:0] pay;
    int              tail;
    logic            exp_err;
    int              exp_len;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rmii_clk = 1'b0;
  logic        fast_eth;
  logic        rm_crs_dv;
  logic [1:0]  rm_rx_data;
  logic [7:0]  data;
  logic        valid;
  logic        sof;
  logic        eof;
  logic        err;
  logic [10:0] frame_len;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int hold     = 1;

  int         sof_cnt = 0;
  int         eof_cnt = 0;
  int         mon_bad = 0;
  logic       eof_err = 1'b0;
  int         eof_len = 0;
  logic [7:0] got_q[$];
  longint     vt_q[$];
  logic [7:0] pay_buf [0:2063];
  vec_t       vecs [6];

  rmii_recv_byte dut (
    .clk        (clk),
    .rst        (rst),
    .rmii_clk   (rmii_clk),
    .fast_eth   (fast_eth),
    .rm_crs_dv  (rm_crs_dv),
    .rm_rx_data (rm_rx_data),
    .data       (data),
    .valid      (valid),
    .sof        (sof),
    .eof        (eof),
    .err        (err),
    .frame_len  (frame_len),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always #10 rmii_clk = ~rmii_clk;

  // Output monitor, sampled on the falling clk edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (valid) begin
          got_q.push_back(data);
          vt_q.push_back(longint'($time));
        end
        if (sof) sof_cnt++;
        if (eof) begin
          eof_cnt++;
          eof_err = err;
          eof_len = int'(frame_len);
        end
        if (valid && eof) mon_bad++;
        if ((sof || valid || eof) && !busy) mon_bad++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " data"},      int'(data),      0);
    check({tag, " valid"},     int'(valid),     0);
    check({tag, " sof"},       int'(sof),       0);
    check({tag, " eof"},       int'(eof),       0);
    check({tag, " err"},       int'(err),       0);
    check({tag, " frame_len"}, int'(frame_len), 0);
    check({tag, " busy"},      int'(busy),      0);
  endtask

  // Advance past the next clk edge at which rmii_clk is high
  task automatic tick_rmii();
    @(posedge clk);
    while (rmii_clk !== 1'b1) @(posedge clk);
    #1;
  endtask

  task automatic rx_sym(input logic crs, input logic [1:0] d);
    rm_crs_dv  = crs;
    rm_rx_data = d;
    repeat (hold) tick_rmii();
  endtask

  task automatic send_head(input logic fast);
    fast_eth = fast;
    hold     = fast ? 1 : 10;
    for (int i = 0; i < 31; i++) rx_sym(1'b1, 2'b01);
    rx_sym(1'b1, 2'b11);
  endtask

  task automatic send_frame(input logic fast, input int n, input int tail);
    logic [7:0] b;
    logic       crs;
    send_head(fast);
    for (int i = 0; i < n; i++) begin
      b = pay_buf[i];
      for (int j = 0; j < 4; j++) begin
        crs = (tail == T_TOGGLE && i == n - 1) ? (j % 2 == 1) : 1'b1;
        rx_sym(crs, b[2*j +: 2]);
      end
    end
    if (tail == T_EXTRA3) begin
      rx_sym(1'b1, 2'b11);
      rx_sym(1'b1, 2'b10);
      rx_sym(1'b1, 2'b01);
    end
    for (int i = 0; i < 5; i++) rx_sym(1'b0, 2'b00);
  endtask

  task automatic run_frame(input logic fast, input int n, input int tail,
                           input logic exp_err, input int exp_len, input string tag);
    int sof0, eof0, bad0, k;
    got_q.delete();
    vt_q.delete();
    sof0 = sof_cnt;
    eof0 = eof_cnt;
    bad0 = mon_bad;
    send_frame(fast, n, tail);
    k = 0;
    while (eof_cnt == eof0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    check({tag, " sof count"},   sof_cnt - sof0, 1);
    check({tag, " eof count"},   eof_cnt - eof0, 1);
    check({tag, " err"},         int'(eof_err), int'(exp_err));
    check({tag, " frame_len"},   eof_len, exp_len);
    check({tag, " valid count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check({tag, " data"}, int'(got_q[i]), int'(pay_buf[i]));
    if (!fast)
      for (int i = 1; i < vt_q.size(); i++)
        check({tag, " valid spacing ns"}, int'(vt_q[i] - vt_q[i-1]), 800);
    check({tag, " strobe/busy rule"}, mon_bad - bad0, 0);
    check({tag, " busy after"},       int'(busy), 0);
  endtask

  initial begin
    int sof0, eof0, nv0;

    vecs[0] = '{fast: 1'b1, n: 3, pay: {8'h00, 8'hFF, 8'h02, 8'h01}, tail: T_NORMAL, exp_err: 1'b0, exp_len: 3};
    vecs[1] = '{fast: 1'b0, n: 3, pay: {8'h00, 8'hFF, 8'h02, 8'h01}, tail: T_NORMAL, exp_err: 1'b0, exp_len: 3};
    vecs[2] = '{fast: 1'b1, n: 3, pay: {8'h00, 8'hA5, 8'h22, 8'h11}, tail: T_TOGGLE, exp_err: 1'b0, exp_len: 3};
    vecs[3] = '{fast: 1'b1, n: 2, pay: {8'h00, 8'h00, 8'hC3, 8'h3C}, tail: T_EXTRA3, exp_err: 1'b1, exp_len: 2};
    vecs[4] = '{fast: 1'b0, n: 1, pay: {8'h00, 8'h00, 8'h00, 8'hA5}, tail: T_TOGGLE, exp_err: 1'b0, exp_len: 1};
    vecs[5] = '{fast: 1'b1, n: 0, pay: {8'h00, 8'h00, 8'h00, 8'h00}, tail: T_NORMAL, exp_err: 1'b0, exp_len: 0};

    rst        = 1'b0;
    fast_eth   = 1'b1;
    rm_crs_dv  = 1'b0;
    rm_rx_data = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) pay_buf[i] = vecs[v].pay[i];
      run_frame(vecs[v].fast, vecs[v].n, vecs[v].tail, vecs[v].exp_err,
                vecs[v].exp_len, $sformatf("vec%0d", v));
    end

    // Preamble broken by a 10 dibit and never completed: nothing reported
    sof0 = sof_cnt;
    eof0 = eof_cnt;
    nv0  = got_q.size();
    fast_eth = 1'b1;
    hold     = 1;
    for (int i = 0; i < 6; i++) rx_sym(1'b1, 2'b01);
    rx_sym(1'b1, 2'b10);
    for (int i = 0; i < 4; i++) rx_sym(1'b1, 2'b01);
    for (int i = 0; i < 6; i++) rx_sym(1'b0, 2'b00);
    check("abort sof",   sof_cnt - sof0, 0);
    check("abort eof",   eof_cnt - eof0, 0);
    check("abort valid", got_q.size() - nv0, 0);
    check("abort busy",  int'(busy), 0);
    for (int i = 0; i < 4; i++) pay_buf[i] = vecs[0].pay[i];
    run_frame(1'b1, 3, T_NORMAL, 1'b0, 3, "after abort");

    // Long frame: length sticks at 2047
    for (int i = 0; i < 2050; i++) pay_buf[i] = 8'(i * 7 + 3);
    run_frame(1'b1, 2050, T_NORMAL, 1'b0, 2047, "saturate");

    // One-cycle reset in the middle of a payload byte
    send_head(1'b1);
    rx_sym(1'b1, 2'b01);
    rx_sym(1'b1, 2'b00);
    rx_sym(1'b1, 2'b00);
    rx_sym(1'b1, 2'b00);
    rx_sym(1'b1, 2'b10);
    rx_sym(1'b1, 2'b00);
    sof0 = sof_cnt;
    eof0 = eof_cnt;
    rm_crs_dv  = 1'b0;
    rm_rx_data = 2'b00;
    rst        = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_all_zero("mid reset");
    repeat (40) @(posedge clk);
    #1;
    check("mid reset eof", eof_cnt - eof0, 0);
    check("mid reset sof", sof_cnt - sof0, 0);
    pay_buf[0] = 8'h5A;
    pay_buf[1] = 8'h96;
    run_frame(1'b1, 2, T_NORMAL, 1'b0, 2, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
